// File: rtl/and_tree_tb_pkg.sv
// Shared types and constants for the AND-tree stimulus/response checker.
//   state_t    : sequencer states
//   LFSR_SEED  : LFSR value loaded at the start of every run
//   LFSR_TAPS  : feedback mask for the right-shifting 16-bit Fibonacci LFSR
//                (polynomial taps 16,14,13,11 map to bits 0,2,3,5)
//   result_t   : pass/fail/timeout triple for scoreboards
//   lfsr_step  : one LFSR advance
package and_tree_tb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_WAIT,
      ST_ADVANCE,
      ST_DONE
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef struct packed {
      logic [15:0] pass;
      logic [15:0] fail;
      logic [15:0] timeout;
   } result_t;

   // Feedback bit is shifted in at the MSB, everything else moves down one.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single bit arriving asynchronously to clk.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears both stages to 0
//   d     : asynchronous input
//   q     : synchronised output (two clk cycles of latency)
module bit_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_reg;
   logic s2_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
      end else begin
         s1_reg <= d;
         s2_reg <= s1_reg;
      end
   end

   assign q = s2_reg;

endmodule

// File: rtl/and_tree_vec_checker.sv
// Stimulus/response sequencer around a co-simulated AND tree.
// Drives a vector onto the tree inputs, waits for the synchronised tree
// output to match the expected AND for SETTLE_CYC consecutive cycles (pass)
// or gives up after TIMEOUT_CYC cycles (fail + timeout), then advances.
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse, begins a run when idle
//   mode              : 0 = exhaustive sweep, 1 = LFSR vectors
//   num_vec           : vectors per run (0 = finish immediately)
//   dut_in            : registered drive to the tree inputs
//   dut_out           : tree output, asynchronous to clk
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   pass_cnt, fail_cnt, timeout_cnt : saturating result counters
//   first_fail_vec, first_fail_valid : first failing vector of the run
module and_tree_vec_checker
   import and_tree_tb_pkg::*;
#(
   parameter int N_IN        = 4,
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] num_vec,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic             first_fail_valid
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SW-1:0] SETTLE_LIM  = SW'(SETTLE_CYC);
   localparam logic [WW-1:0] TIMEOUT_LIM = WW'(TIMEOUT_CYC);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  vec_idx_reg, vec_idx_next;
   logic [CNT_W-1:0]  num_vec_reg, num_vec_next;
   logic              mode_reg, mode_next;
   logic [15:0]       lfsr_reg, lfsr_next;
   logic [N_IN-1:0]   dut_in_reg, dut_in_next;
   logic [WW-1:0]     wait_cnt_reg, wait_cnt_next;
   logic [SW-1:0]     stable_cnt_reg, stable_cnt_next;
   logic [CNT_W-1:0]  pass_cnt_reg, pass_cnt_next;
   logic [CNT_W-1:0]  fail_cnt_reg, fail_cnt_next;
   logic [CNT_W-1:0]  timeout_cnt_reg, timeout_cnt_next;
   logic [N_IN-1:0]   ff_vec_reg, ff_vec_next;
   logic              ff_valid_reg, ff_valid_next;
   // Marks that the vector just finished in WAIT failed; consumed in ADVANCE.
   logic              fail_flag_reg, fail_flag_next;

   logic              z_s;
   logic              match;
   logic [WW-1:0]     wait_inc;
   logic [SW-1:0]     stable_inc;

   bit_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (dut_out),
      .q     (z_s)
   );

   assign match      = (z_s == (&dut_in_reg));
   assign wait_inc   = wait_cnt_reg + WW'(1);
   assign stable_inc = stable_cnt_reg + SW'(1);

   always_comb begin
      state_next       = state_reg;
      vec_idx_next     = vec_idx_reg;
      num_vec_next     = num_vec_reg;
      mode_next        = mode_reg;
      lfsr_next        = lfsr_reg;
      dut_in_next      = dut_in_reg;
      wait_cnt_next    = wait_cnt_reg;
      stable_cnt_next  = stable_cnt_reg;
      pass_cnt_next    = pass_cnt_reg;
      fail_cnt_next    = fail_cnt_reg;
      timeout_cnt_next = timeout_cnt_reg;
      ff_vec_next      = ff_vec_reg;
      ff_valid_next    = ff_valid_reg;
      fail_flag_next   = fail_flag_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               pass_cnt_next    = '0;
               fail_cnt_next    = '0;
               timeout_cnt_next = '0;
               ff_vec_next      = '0;
               ff_valid_next    = 1'b0;
               fail_flag_next   = 1'b0;
               vec_idx_next     = '0;
               lfsr_next        = LFSR_SEED;
               mode_next        = mode;
               num_vec_next     = num_vec;
               state_next       = ST_APPLY;
            end
         end
         ST_APPLY: begin
            if (vec_idx_reg == num_vec_reg) begin
               state_next = ST_DONE;
            end else begin
               // Sweep index wraps naturally by taking the low N_IN bits.
               dut_in_next     = mode_reg ? lfsr_reg[N_IN-1:0] : vec_idx_reg[N_IN-1:0];
               wait_cnt_next   = '0;
               stable_cnt_next = '0;
               fail_flag_next  = 1'b0;
               state_next      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wait_cnt_next   = wait_inc;
            stable_cnt_next = match ? stable_inc : '0;
            // Pass is tested first so it wins over a simultaneous timeout.
            if (match && (stable_inc == SETTLE_LIM)) begin
               pass_cnt_next = sat_inc(pass_cnt_reg);
               state_next    = ST_ADVANCE;
            end else if (wait_inc == TIMEOUT_LIM) begin
               fail_cnt_next    = sat_inc(fail_cnt_reg);
               timeout_cnt_next = sat_inc(timeout_cnt_reg);
               fail_flag_next   = 1'b1;
               state_next       = ST_ADVANCE;
            end
         end
         ST_ADVANCE: begin
            vec_idx_next = vec_idx_reg + CNT_W'(1);
            if (mode_reg) begin
               lfsr_next = lfsr_step(lfsr_reg);
            end
            if (fail_flag_reg && !ff_valid_reg) begin
               ff_vec_next   = dut_in_reg;
               ff_valid_next = 1'b1;
            end
            state_next = ST_APPLY;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         vec_idx_reg     <= '0;
         num_vec_reg     <= '0;
         mode_reg        <= 1'b0;
         lfsr_reg        <= LFSR_SEED;
         dut_in_reg      <= '0;
         wait_cnt_reg    <= '0;
         stable_cnt_reg  <= '0;
         pass_cnt_reg    <= '0;
         fail_cnt_reg    <= '0;
         timeout_cnt_reg <= '0;
         ff_vec_reg      <= '0;
         ff_valid_reg    <= 1'b0;
         fail_flag_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         vec_idx_reg     <= vec_idx_next;
         num_vec_reg     <= num_vec_next;
         mode_reg        <= mode_next;
         lfsr_reg        <= lfsr_next;
         dut_in_reg      <= dut_in_next;
         wait_cnt_reg    <= wait_cnt_next;
         stable_cnt_reg  <= stable_cnt_next;
         pass_cnt_reg    <= pass_cnt_next;
         fail_cnt_reg    <= fail_cnt_next;
         timeout_cnt_reg <= timeout_cnt_next;
         ff_vec_reg      <= ff_vec_next;
         ff_valid_reg    <= ff_valid_next;
         fail_flag_reg   <= fail_flag_next;
      end
   end

   assign dut_in           = dut_in_reg;
   assign busy             = (state_reg == ST_APPLY) || (state_reg == ST_WAIT) ||
                             (state_reg == ST_ADVANCE);
   assign done             = (state_reg == ST_DONE);
   assign pass_cnt         = pass_cnt_reg;
   assign fail_cnt         = fail_cnt_reg;
   assign timeout_cnt      = timeout_cnt_reg;
   assign first_fail_vec   = ff_vec_reg;
   assign first_fail_valid = ff_valid_reg;

endmodule

// File: tb/tb_and_tree_vec_checker.sv
// Self-checking bench for and_tree_vec_checker. The AND tree is modelled as
// ideal, stuck-at-0 or stuck-at-1; expected results come from a
// vector-list reference model.
module tb_and_tree_vec_checker;
   import and_tree_tb_pkg::*;

   localparam int N_IN        = 4;
   localparam int CNT_W       = 16;
   localparam int SETTLE_CYC  = 4;
   localparam int TIMEOUT_CYC = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic [CNT_W-1:0] num_vec = '0;
   logic [N_IN-1:0]  dut_in;
   logic             dut_out;
   logic             busy, done;
   logic [CNT_W-1:0] pass_cnt, fail_cnt, timeout_cnt;
   logic [N_IN-1:0]  first_fail_vec;
   logic             first_fail_valid;

   int fault = 0;   // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
   int checks = 0;
   int failures = 0;

   assign dut_out = (fault == 0) ? (&dut_in) : ((fault == 1) ? 1'b0 : 1'b1);

   always #5 clk = ~clk;

   and_tree_vec_checker #(
      .N_IN(N_IN), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vec(num_vec),
      .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
      .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, dut_in, pass_cnt, fail_cnt, timeout_cnt, first_fail_vec, first_fail_valid} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b dut_in=%h pass=%0d fail=%0d to=%0d ffv=%h ffval=%b required all 0",
                  busy, done, dut_in, pass_cnt, fail_cnt, timeout_cnt, first_fail_vec, first_fail_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      $display("test_reset: done");
   endtask

   // Runs one complete vector run and checks every result against the model.
   task automatic run_and_check(input int m, input int n, input int f, input string name);
      logic [N_IN-1:0] vecs[$];
      logic [N_IN-1:0] exp_seq[$];
      logic [N_IN-1:0] seen[$];
      logic [N_IN-1:0] prev, start_in;
      result_t exp_r;
      int s, fb, ff_exp, cyc, bound;
      bit ff_has, got_done, seq_ok;

      fault = f;
      // Reference: list of vectors, then per-vector verdict from the fault model.
      s = 'hACE1;
      for (int i = 0; i < n; i++) begin
         vecs.push_back(m ? N_IN'(s & 15) : N_IN'(i % 16));
         if (m) begin
            fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s  = (s >> 1) | (fb << 15);
         end
      end
      exp_r = '0;
      ff_has = 0;
      ff_exp = 0;
      foreach (vecs[i]) begin
         bit e, z;
         e = (vecs[i] == 4'hF);
         z = (f == 0) ? e : ((f == 1) ? 1'b0 : 1'b1);
         if (z == e) exp_r.pass++;
         else begin
            exp_r.fail++;
            exp_r.timeout++;
            if (!ff_has) begin
               ff_has = 1;
               ff_exp = int'(vecs[i]);
            end
         end
      end
      start_in = dut_in;
      prev = start_in;
      foreach (vecs[i]) begin
         if (vecs[i] != prev) exp_seq.push_back(vecs[i]);
         prev = vecs[i];
      end

      // Drive the run; mode/num_vec are scrambled right after start.
      @(negedge clk);
      start = 1'b1;
      mode = m[0];
      num_vec = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
      mode = 1'($urandom);
      num_vec = CNT_W'($urandom);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL %s.busy_after_start got=%b required=1", name, busy);
      end
      prev = start_in;
      cyc = 1;
      got_done = 0;
      bound = n * (TIMEOUT_CYC + 6) + 10;
      for (int k = 1; k <= bound; k++) begin
         @(negedge clk);
         cyc++;
         if (k == 3) start = 1'b1;   // must be ignored while busy
         if (k == 4) start = 1'b0;
         if (dut_in != prev) seen.push_back(dut_in);
         prev = dut_in;
         if (done === 1'b1) begin
            got_done = 1;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (!got_done) begin
         failures++;
         $display("FAIL %s.done_timeout got=no_done_after_%0d_cycles required=done", name, cyc);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         return;
      end
      if (n == 0) begin
         checks++;
         if (cyc != 2) begin
            failures++;
            $display("FAIL %s.zero_latency got=%0d required=2", name, cyc);
         end
      end else if (f == 0) begin
         checks++;
         if (cyc > n * (SETTLE_CYC + 4) + 2) begin
            failures++;
            $display("FAIL %s.latency got=%0d required<=%0d", name, cyc, n * (SETTLE_CYC + 4) + 2);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s.busy_in_done got=%b required=0", name, busy);
      end
      checks++;
      if (pass_cnt !== exp_r.pass || fail_cnt !== exp_r.fail || timeout_cnt !== exp_r.timeout) begin
         failures++;
         $display("FAIL %s.counters got=%0d/%0d/%0d required=%0d/%0d/%0d", name,
                  pass_cnt, fail_cnt, timeout_cnt, exp_r.pass, exp_r.fail, exp_r.timeout);
      end
      checks++;
      if (first_fail_valid !== ff_has || (ff_has && first_fail_vec !== N_IN'(ff_exp))) begin
         failures++;
         $display("FAIL %s.first_fail got=%b/%h required=%b/%h", name,
                  first_fail_valid, first_fail_vec, ff_has, ff_exp);
      end
      seq_ok = (seen.size() == exp_seq.size());
      if (seq_ok) foreach (seen[i]) if (seen[i] != exp_seq[i]) seq_ok = 0;
      checks++;
      if (!seq_ok) begin
         failures++;
         $display("FAIL %s.vector_sequence got=%0d_changes required=%0d_changes", name, seen.size(), exp_seq.size());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dut_in !== (n == 0 ? start_in : vecs[n-1])) begin
         failures++;
         $display("FAIL %s.after_done got=done%b busy%b dut_in=%h required=done0 busy0 dut_in=%h",
                  name, done, busy, dut_in, (n == 0 ? start_in : vecs[n-1]));
      end
      $display("%s: mode=%0d n=%0d fault=%0d pass=%0d fail=%0d timeout=%0d cycles=%0d",
               name, m, n, f, pass_cnt, fail_cnt, timeout_cnt, cyc);
   endtask

   task automatic test_mid_run_reset();
      bit hit;
      bit saw_done;
      fault = 0;
      @(negedge clk);
      start = 1'b1;
      mode = 1'b0;
      num_vec = 16;
      @(negedge clk);
      start = 1'b0;
      hit = 0;
      for (int k = 0; k < 200; k++) begin
         if (dut_in == 4'h5) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL mid_reset.reach_vec5 got=dut_in_%h required=5", dut_in);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== '0 || fail_cnt !== '0 ||
          timeout_cnt !== '0 || first_fail_valid !== 1'b0 || dut_in !== '0) begin
         failures++;
         $display("FAIL mid_reset.cleared got busy=%b done=%b pass=%0d fail=%0d dut_in=%h required zeros",
                  busy, done, pass_cnt, fail_cnt, dut_in);
      end
      reset = 1'b0;
      saw_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL mid_reset.no_done got=activity_after_reset required=idle");
      end
      $display("test_mid_run_reset: reset applied at vector 5");
      run_and_check(0, 16, 0, "replay_after_reset");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++)
         run_and_check(int'($urandom_range(0, 1)), int'($urandom_range(1, 40)),
                       int'($urandom_range(0, 2)), "random");
   endtask

   initial begin
      test_reset();
      run_and_check(0, 16, 0, "ideal_sweep");
      run_and_check(0, 16, 1, "stuck0");
      run_and_check(0, 16, 2, "stuck1");
      run_and_check(0, 0, 0, "zero_vec");
      run_and_check(1, 8, 0, "lfsr");
      run_and_check(0, 20, 0, "sweep_wrap");
      test_mid_run_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/and_tree_vec_checker.md
Name: and_tree_vec_checker

Overview:
- Clocked stimulus/response stage wrapped around a prsim co-simulated AND-tree.
- Upstream side: drives the N_IN tree inputs (TOP.a..d) through $to_prsim nets.
- Downstream side: consumes the tree output (TOP.z) from $from_prsim, compares it to the expected AND, and counts pass, fail and timeout events.
- Replaces hand-written `#delay` stimulus with a self-checking, reusable sequencer.

Parameters:
- N_IN, 4: number of tree inputs.
- CNT_W, 16: width of the vector counter and the result counters.
- SETTLE_CYC, 4: consecutive cycles a matching output must hold before a vector passes.
- TIMEOUT_CYC, 64: maximum cycles to wait per vector before declaring a fail.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when IDLE.
- mode  in  1  0 = exhaustive sweep (0,1,2,...); 1 = 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11).
- num_vec  in  CNT_W  number of vectors per run; 0 means run completes immediately.
- dut_in  out  N_IN  registered drive to tree inputs.
- dut_out  in  1  tree output; asynchronous to clk.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse at run end.
- pass_cnt  out  CNT_W  vectors passed.
- fail_cnt  out  CNT_W  vectors failed (mismatch or timeout).
- timeout_cnt  out  CNT_W  subset of fails caused by timeout.
- first_fail_vec  out  N_IN  first failing vector of the run.
- first_fail_valid  out  1  first_fail_vec holds a value.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, sync flops 0, LFSR = seed.
- dut_out passes through a 2-flop synchroniser (z_s) before any use.
- Expected value: exp = &dut_in.
- IDLE:
  - start=1 → clear all counters and first_fail_*, load vec_idx=0, reload LFSR seed, go to APPLY.
  - start while busy is ignored.
- APPLY (1 cycle):
  - If vec_idx==num_vec → DONE.
  - Else dut_in <= (mode ? lfsr[N_IN-1:0] : vec_idx[N_IN-1:0]); clear wait_cnt and stable_cnt; go to WAIT.
- WAIT:
  - Each cycle wait_cnt++.
  - If z_s==exp, stable_cnt++; else stable_cnt=0.
  - stable_cnt reaches SETTLE_CYC → pass_cnt++ → ADVANCE.
  - wait_cnt reaches TIMEOUT_CYC without a pass → fail_cnt++, timeout_cnt++ → ADVANCE.
  - If pass and timeout coincide in the same cycle, pass wins.
- ADVANCE (1 cycle):
  - vec_idx++; LFSR steps once (only in mode 1).
  - On any fail with first_fail_valid=0: capture dut_in, set first_fail_valid.
  - Go to APPLY.
- DONE (1 cycle): done=1, busy=0, go to IDLE.
- Sweep wrap: vec_idx above 2^N_IN-1 wraps dut_in modulo 2^N_IN; num_vec is not clipped.
- Counters saturate at all-ones; no wrap.
- dut_in holds its last value in IDLE/DONE.
- Latency per vector: 1 (APPLY) + ≥SETTLE_CYC + 2 (sync) + 1 (ADVANCE) cycles minimum.
- Reset mid-run returns to IDLE within the same edge and clears everything; no done pulse is produced.
- Mode and num_vec are sampled only at start; later changes are ignored until the next run.

Decomposition:
- Shared package and_tree_tb_pkg holds:
  - FSM state enum (IDLE, APPLY, WAIT, ADVANCE, DONE).
  - LFSR_SEED and LFSR_TAPS constants.
  - A result struct {pass, fail, timeout} for bench scoreboards.
- One natural sub-module: bit_sync2 (2-flop synchroniser, reset to 0), reusable by all $from_prsim consumers.

Test Plan:
- Ideal tree (prsim and_tree object), mode=0, num_vec=16 → done after ≤16*(SETTLE_CYC+4)+2 cycles; pass_cnt=16, fail_cnt=0, first_fail_valid=0.
- Force TOP.z stuck-at-0, mode=0, num_vec=16 → vector 4'hF never matches; fail_cnt=1, timeout_cnt=1, pass_cnt=15, first_fail_vec=4'hF.
- Force z stuck-at-1 → fail_cnt=15, first_fail_vec=4'h0.
- num_vec=0 with start → done pulses 2 cycles after start; all counters 0; dut_in unchanged.
- mode=1, num_vec=8 → dut_in sequence equals the low 4 bits of successive LFSR states from 16'hACE1; pass_cnt=8.
- Assert reset while in WAIT at vector 5 → next cycle busy=0, counters 0; a fresh start replays from vector 0.
